// File: rtl/riscv_pkg.sv
// Shared RV32 constants and the fetch-stage state encoding.
package riscv_pkg;

   localparam int XLEN = 32;
   localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

   typedef enum logic [1:0] {
      ISSUE = 2'd0,
      WAIT  = 2'd1,
      FULL  = 2'd2
   } fetch_state_e;

endpackage

// File: rtl/fetch_next_pc.sv
// Redirect qualification, target selection and alignment check for the fetch PC.
module fetch_next_pc
   import riscv_pkg::*;
(
   input  logic            i_valid,
   input  logic            i_stall,
   input  logic            i_br_en,
   input  logic            i_jal_en,
   input  logic            i_jalr_en,
   input  logic [XLEN-1:0] i_jalr_pc,
   input  logic [XLEN-1:0] i_pc,
   input  logic [XLEN-1:0] i_imm,
   output logic            o_redirect,
   output logic            o_misaligned,
   output logic [XLEN-1:0] o_target
);

   logic [XLEN-1:0] w_raw;

   // Branch and JAL share the pc-relative target, so only JALR needs priority.
   always_comb begin
      w_raw = i_pc + i_imm;
      if (i_jalr_en) w_raw = {i_jalr_pc[XLEN-1:1], 1'b0};
   end

   assign o_redirect   = i_valid & ~i_stall & (i_br_en | i_jal_en | i_jalr_en);
   assign o_misaligned = o_redirect & w_raw[1];
   assign o_target     = {w_raw[XLEN-1:2], 2'b00};

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch with one outstanding imem request, a one-entry skid and the IF/ID register.
module fetch_stage
   import riscv_pkg::*;
#(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = riscv_pkg::NOP_INSTR
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall,
   input  logic        br_en,
   input  logic        jal_en,
   input  logic        jalr_en,
   input  logic [31:0] jalr_PC,
   input  logic [31:0] id_imm,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_gnt,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   output logic        if_id_valid,
   output logic [31:0] if_id_pc,
   output logic [31:0] if_id_instr,
   output logic        redirect,
   output logic        misaligned
);

   fetch_state_e r_state, w_next;
   logic [31:0]  r_pc, r_skid_pc, r_skid_instr, r_id_pc, r_id_instr;
   logic         r_kill, r_valid, r_mis;
   logic [31:0]  w_target;
   logic         w_redirect, w_mis, w_gnt, w_rsp_ok, w_to_ifid, w_to_skid, w_skid_pop;

   fetch_next_pc u_next_pc (
      .i_valid      (r_valid),
      .i_stall      (stall),
      .i_br_en      (br_en),
      .i_jal_en     (jal_en),
      .i_jalr_en    (jalr_en),
      .i_jalr_pc    (jalr_PC),
      .i_pc         (r_id_pc),
      .i_imm        (id_imm),
      .o_redirect   (w_redirect),
      .o_misaligned (w_mis),
      .o_target     (w_target)
   );

   assign w_gnt      = (r_state == ISSUE) & imem_gnt;
   assign w_rsp_ok   = (r_state == WAIT) & imem_rvalid & ~r_kill & ~w_redirect;
   assign w_to_ifid  = w_rsp_ok & (~stall | ~r_valid);
   assign w_to_skid  = w_rsp_ok & stall & r_valid;
   assign w_skid_pop = (r_state == FULL) & ~stall & ~w_redirect;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= ISSUE;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         ISSUE:   if (w_gnt) w_next = WAIT;
         WAIT:    if (imem_rvalid) w_next = w_to_skid ? FULL : ISSUE;
         FULL:    if (~stall) w_next = ISSUE;
         default: w_next = ISSUE;
      endcase
   end

   // Request drops with reset so the memory never sees a fetch while the PC is being reloaded.
   always_comb begin
      imem_req  = ~rst & (r_state == ISSUE) & ~w_redirect;
      imem_addr = r_pc;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_pc         <= RESET_PC;
         r_kill       <= 1'b0;
         r_skid_pc    <= '0;
         r_skid_instr <= '0;
         r_mis        <= 1'b0;
      end else begin
         if (w_redirect)  r_pc <= w_target;
         else if (w_gnt)  r_pc <= r_pc + 32'd4;
         // A response still in flight at redirect belongs to the wrong path.
         if (w_redirect & (((r_state == WAIT) & ~imem_rvalid) | w_gnt)) r_kill <= 1'b1;
         else if ((r_state == WAIT) & imem_rvalid)                      r_kill <= 1'b0;
         if (w_to_skid) begin
            r_skid_pc    <= r_pc - 32'd4;
            r_skid_instr <= imem_rdata;
         end
         if (w_mis) r_mis <= 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_valid    <= 1'b0;
         r_id_pc    <= '0;
         r_id_instr <= NOP_INSTR;
      end else if (w_redirect) begin
         r_valid    <= 1'b0;
         r_id_instr <= NOP_INSTR;
      end else if (w_to_ifid) begin
         r_valid    <= 1'b1;
         r_id_pc    <= r_pc - 32'd4;
         r_id_instr <= imem_rdata;
      end else if (w_skid_pop) begin
         r_valid    <= 1'b1;
         r_id_pc    <= r_skid_pc;
         r_id_instr <= r_skid_instr;
      end else if (~stall) begin
         r_valid    <= 1'b0;
         r_id_instr <= NOP_INSTR;
      end
   end

   assign if_id_valid = r_valid;
   assign if_id_pc    = r_id_pc;
   assign if_id_instr = r_id_instr;
   assign redirect    = w_redirect;
   assign misaligned  = r_mis;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: a one-outstanding memory answers each grant one cycle later
// with data 0xC000_0000 | addr; rv_en holds a response back when a step needs it in flight.
module tb_fetch_stage;

   logic        clk = 1'b0, rst = 1'b0, stall = 1'b0;
   logic        br_en = 1'b0, jal_en = 1'b0, jalr_en = 1'b0;
   logic [31:0] jalr_PC = '0, id_imm = '0;
   logic        imem_req, imem_gnt, imem_rvalid;
   logic [31:0] imem_addr, imem_rdata;
   logic        if_id_valid, redirect, misaligned;
   logic [31:0] if_id_pc, if_id_instr;

   logic        rv_en = 1'b1, m_pend = 1'b0;
   logic [31:0] m_addr = '0;
   int          vectors = 0, errors = 0;

   fetch_stage dut (
      .clk(clk), .rst(rst), .stall(stall),
      .br_en(br_en), .jal_en(jal_en), .jalr_en(jalr_en), .jalr_PC(jalr_PC), .id_imm(id_imm),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
      .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
      .if_id_valid(if_id_valid), .if_id_pc(if_id_pc), .if_id_instr(if_id_instr),
      .redirect(redirect), .misaligned(misaligned)
   );

   always #5 clk = ~clk;

   assign imem_gnt    = imem_req & ~m_pend;
   assign imem_rvalid = m_pend & rv_en;
   assign imem_rdata  = imem_rvalid ? (32'hC000_0000 | m_addr) : 32'hDEAD_BEEF;

   always @(posedge clk) begin
      if (imem_gnt) begin
         m_pend <= 1'b1;
         m_addr <= imem_addr;
      end else if (imem_rvalid) begin
         m_pend <= 1'b0;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, " req"},   {31'd0, imem_req},    32'd0);
      chk({tag, " valid"}, {31'd0, if_id_valid}, 32'd0);
      chk({tag, " pc"},    if_id_pc,             32'h0);
      chk({tag, " instr"}, if_id_instr,          32'h13);
      chk({tag, " mis"},   {31'd0, misaligned},  32'd0);
      chk({tag, " redir"}, {31'd0, redirect},    32'd0);
   endtask

   initial begin
      #1 rst = 1'b1;
      #1 chk_reset("rst0");
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      #1;
      // C0: first fetch at RESET_PC
      chk("c0 addr", imem_addr, 32'h0);
      chk("c0 req", {31'd0, imem_req}, 32'd1);
      cyc(); #1;
      chk("c1 req", {31'd0, imem_req}, 32'd0);
      chk("c1 valid", {31'd0, if_id_valid}, 32'd0);
      cyc(); #1;
      chk("c2 valid", {31'd0, if_id_valid}, 32'd1);
      chk("c2 pc", if_id_pc, 32'h0);
      chk("c2 instr", if_id_instr, 32'hC000_0000);
      chk("c2 addr", imem_addr, 32'h4);
      cyc(); #1;
      chk("c3 bubble", {31'd0, if_id_valid}, 32'd0);
      // C4: stall masks a JAL; request for 0x8 still issues
      cyc(); stall = 1'b1; jal_en = 1'b1; rv_en = 1'b0; #1;
      chk("c4 valid", {31'd0, if_id_valid}, 32'd1);
      chk("c4 pc", if_id_pc, 32'h4);
      chk("c4 redir masked", {31'd0, redirect}, 32'd0);
      chk("c4 req", {31'd0, imem_req}, 32'd1);
      chk("c4 addr", imem_addr, 32'h8);
      // C5: JAL in WAIT with 0x8 outstanding, target 0x4+0xFC
      cyc(); stall = 1'b0; id_imm = 32'h0000_00FC; #1;
      chk("c5 redir", {31'd0, redirect}, 32'd1);
      chk("c5 req", {31'd0, imem_req}, 32'd0);
      cyc(); jal_en = 1'b0; rv_en = 1'b1; #1;
      chk("c6 valid", {31'd0, if_id_valid}, 32'd0);
      chk("c6 instr", if_id_instr, 32'h13);
      chk("c6 req", {31'd0, imem_req}, 32'd0);
      cyc(); #1;
      chk("c7 addr", imem_addr, 32'h100);
      chk("c7 req", {31'd0, imem_req}, 32'd1);
      chk("c7 killed", {31'd0, if_id_valid}, 32'd0);
      cyc(); #1;
      chk("c8 valid", {31'd0, if_id_valid}, 32'd0);
      // C9: branch at 0x100 with imm -16
      cyc(); br_en = 1'b1; id_imm = 32'hFFFF_FFF0; #1;
      chk("c9 valid", {31'd0, if_id_valid}, 32'd1);
      chk("c9 pc", if_id_pc, 32'h100);
      chk("c9 instr", if_id_instr, 32'hC000_0100);
      chk("c9 redir", {31'd0, redirect}, 32'd1);
      chk("c9 req", {31'd0, imem_req}, 32'd0);
      cyc(); br_en = 1'b0; #1;
      chk("c10 addr", imem_addr, 32'hF0);
      chk("c10 req", {31'd0, imem_req}, 32'd1);
      chk("c10 valid", {31'd0, if_id_valid}, 32'd0);
      chk("c10 instr", if_id_instr, 32'h13);
      cyc();
      // C12: JALR beats a simultaneous branch; misaligned target
      cyc(); jalr_en = 1'b1; jalr_PC = 32'h0000_2003; br_en = 1'b1; id_imm = 32'h8; #1;
      chk("c12 pc", if_id_pc, 32'hF0);
      chk("c12 redir", {31'd0, redirect}, 32'd1);
      chk("c12 mis pre", {31'd0, misaligned}, 32'd0);
      cyc(); jalr_en = 1'b0; br_en = 1'b0; #1;
      chk("c13 addr", imem_addr, 32'h2000);
      chk("c13 req", {31'd0, imem_req}, 32'd1);
      chk("c13 mis", {31'd0, misaligned}, 32'd1);
      cyc();
      // C15: stall with IF/ID full, response for 0x2004 goes to skid
      cyc(); stall = 1'b1; #1;
      chk("c15 pc", if_id_pc, 32'h2000);
      chk("c15 addr", imem_addr, 32'h2004);
      cyc(); #1;
      chk("c16 held valid", {31'd0, if_id_valid}, 32'd1);
      chk("c16 held pc", if_id_pc, 32'h2000);
      cyc(); #1;
      chk("c17 req", {31'd0, imem_req}, 32'd0);
      chk("c17 pc", if_id_pc, 32'h2000);
      chk("c17 mis sticky", {31'd0, misaligned}, 32'd1);
      cyc(); stall = 1'b0; #1;
      chk("c18 req", {31'd0, imem_req}, 32'd0);
      cyc(); #1;
      chk("c19 valid", {31'd0, if_id_valid}, 32'd1);
      chk("c19 pc", if_id_pc, 32'h2004);
      chk("c19 instr", if_id_instr, 32'hC000_2004);
      chk("c19 addr", imem_addr, 32'h2008);
      chk("c19 req", {31'd0, imem_req}, 32'd1);
      // C20: async reset mid-WAIT
      cyc(); rv_en = 1'b0; #1 rst = 1'b1; #1;
      chk_reset("rst1");
      cyc(); rst = 1'b0; rv_en = 1'b1; #1;
      chk("c21 addr", imem_addr, 32'h0);
      chk("c21 req", {31'd0, imem_req}, 32'd1);
      chk("c21 valid", {31'd0, if_id_valid}, 32'd0);
      cyc(); #1;
      chk("c22 late ignored", {31'd0, if_id_valid}, 32'd0);
      chk("c22 addr", imem_addr, 32'h0);
      cyc(); #1;
      chk("c23 valid", {31'd0, if_id_valid}, 32'd0);
      cyc(); #1;
      chk("c24 valid", {31'd0, if_id_valid}, 32'd1);
      chk("c24 pc", if_id_pc, 32'h0);
      chk("c24 instr", if_id_instr, 32'hC000_0000);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
